// File: rtl/deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : deserializer                                                 |
// | Description : MSB-first serial-to-parallel receiver with short-word support |
// |               via a last flag. Optional partial-word timeout flush when    |
// |               DESERIALIZER_TIMEOUT_EN is defined.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module deserializer #(
    parameter int WIDTH   = 16,
    parameter int MOD_W   = $clog2(WIDTH),
    parameter int TIMEOUT = 32
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic             ser_data_i,
    input  logic             ser_data_val_i,
    input  logic             ser_last_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic [MOD_W-1:0] deser_mod_o,
    output logic             deser_data_val_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam logic [MOD_W-1:0] c_CNT_MAX = MOD_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [MOD_W-1:0] r_cnt;
    logic [MOD_W-1:0] w_pos;
    logic [WIDTH-1:0] w_sr_ins;
    logic             w_full;
    logic             w_done;
    logic             w_flush;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [MOD_W-1:0] w_cnt_nxt;

    if (WIDTH < 4 || TIMEOUT < 1) begin : g_param_check
        $error("deserializer: WIDTH must be >= 4 and TIMEOUT must be >= 1");
    end

    // First bit of a word lands in the MSB; unreceived low bits stay 0.
    always_comb begin
        w_pos           = c_CNT_MAX - r_cnt;
        w_sr_ins        = r_sr;
        w_sr_ins[w_pos] = ser_data_i;
        w_full          = (r_cnt == c_CNT_MAX);
        w_done          = ser_data_val_i && (w_full || ser_last_i);
    end

    always_comb begin
        w_sr_nxt  = r_sr;
        w_cnt_nxt = r_cnt;
        if (w_done || w_flush) begin
            w_sr_nxt  = '0;
            w_cnt_nxt = '0;
        end else if (ser_data_val_i) begin
            w_sr_nxt  = w_sr_ins;
            w_cnt_nxt = r_cnt + MOD_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_sr             <= '0;
            r_cnt            <= '0;
            deser_data_o     <= '0;
            deser_mod_o      <= '0;
            deser_data_val_o <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            r_sr             <= w_sr_nxt;
            r_cnt            <= w_cnt_nxt;
            busy_o           <= (w_cnt_nxt != '0);
            deser_data_val_o <= w_done || w_flush;
            if (w_done) begin
                deser_data_o <= w_sr_ins;
                deser_mod_o  <= w_full ? '0 : r_cnt + MOD_W'(1);
            end else if (w_flush) begin
                deser_data_o <= r_sr;
                deser_mod_o  <= r_cnt;
            end
        end
    end

`ifdef DESERIALIZER_TIMEOUT_EN
    localparam int                  c_IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT - 1);

    logic [c_IDLE_W-1:0] r_idle;
    logic                r_timeout;

    // A bit arriving on the limit cycle suppresses the flush.
    assign w_flush   = busy_o && !ser_data_val_i && (r_idle == c_IDLE_LAST);
    assign timeout_o = r_timeout;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_flush;
            if (!busy_o || ser_data_val_i || w_flush) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + c_IDLE_W'(1);
            end
        end
    end
`else
    assign w_flush   = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_deserializer                                              |
// | Description : Scoreboard bench for deserializer (timeout cases when        |
// |               DESERIALIZER_TIMEOUT_EN is defined).                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_deserializer;

    localparam int c_WIDTH   = 16;
    localparam int c_MOD_W   = 4;
    localparam int c_TIMEOUT = 32;

    logic               clk = 1'b0;
    logic               srst_n_i;
    logic               ser_data_i;
    logic               ser_data_val_i;
    logic               ser_last_i;
    logic [c_WIDTH-1:0] deser_data_o;
    logic [c_MOD_W-1:0] deser_mod_o;
    logic               deser_data_val_o;
    logic               busy_o;
    logic               timeout_o;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  mod;
        logic        to;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_err = 0;

    deserializer #(
        .WIDTH   (c_WIDTH),
        .MOD_W   (c_MOD_W),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk_i            (clk),
        .srst_n_i         (srst_n_i),
        .ser_data_i       (ser_data_i),
        .ser_data_val_i   (ser_data_val_i),
        .ser_last_i       (ser_last_i),
        .deser_data_o     (deser_data_o),
        .deser_mod_o      (deser_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] m, input logic to);
        exp_t e;
        e.data = d;
        e.mod  = m;
        e.to   = to;
        q_exp.push_back(e);
    endtask

    task automatic idle(input int n);
        ser_data_val_i = 1'b0;
        ser_last_i     = 1'b0;
        repeat (n) begin
            ser_data_i = 1'($urandom);
            tick();
        end
    endtask

    // Leaves ser_data_val_i high after the final bit so words can be chained.
    task automatic send_word(input logic [15:0] w, input int n, input bit is_last,
                             input logic [15:0] gap_mask,
                             input logic [15:0] exp_data, input logic [3:0] exp_mod);
        for (int i = 0; i < n; i++) begin
            if (gap_mask[i]) idle(1);
            ser_data_i     = w[15-i];
            ser_data_val_i = 1'b1;
            ser_last_i     = is_last && (i == n - 1);
            if (i == n - 1 && (is_last || n == 16)) push(exp_data, exp_mod, 1'b0);
            tick();
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (deser_data_val_o === 1'b1) begin
                n_vec++;
                if (q_exp.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: got data 0x%0h mod %0d, expected no pulse",
                             deser_data_o, deser_mod_o);
                end else begin
                    e = q_exp.pop_front();
                    if (deser_data_o !== e.data || deser_mod_o !== e.mod || timeout_o !== e.to) begin
                        n_err++;
                        $display("FAIL word: got data 0x%0h mod %0d to %0b, expected data 0x%0h mod %0d to %0b",
                                 deser_data_o, deser_mod_o, timeout_o, e.data, e.mod, e.to);
                    end
                end
            end else if (timeout_o === 1'b1) begin
                n_err++;
                $display("FAIL timeout_no_valid: got timeout_o 1, expected 0");
            end
        end
    end

    initial begin
        logic [15:0] gaps;
        int          pos;

        srst_n_i       = 1'b0;
        ser_data_i     = 1'b0;
        ser_data_val_i = 1'b0;
        ser_last_i     = 1'b0;

        // Reset with random inputs
        repeat (2) begin
            ser_data_i     = 1'($urandom);
            ser_data_val_i = 1'($urandom);
            ser_last_i     = 1'($urandom);
            tick();
        end
        check("rst_data",    32'(deser_data_o),     32'h0);
        check("rst_mod",     32'(deser_mod_o),      32'h0);
        check("rst_val",     32'(deser_data_val_o), 32'h0);
        check("rst_busy",    32'(busy_o),           32'h0);
        check("rst_timeout", 32'(timeout_o),        32'h0);
        srst_n_i = 1'b1;
        idle(2);
        check("busy_after_rst", 32'(busy_o), 32'h0);

        // Full word
        send_word(16'hA5C3, 16, 1'b0, 16'h0, 16'hA5C3, 4'd0);
        idle(1);
        check("busy_after_full", 32'(busy_o), 32'h0);

        // Short word 1,0,1,1,1
        send_word(16'hB800, 5, 1'b1, 16'h0, 16'hB800, 4'd5);
        idle(2);

        // Back-to-back full words, then one with three 1-cycle gaps
        send_word(16'hFFFF, 16, 1'b0, 16'h0, 16'hFFFF, 4'd0);
        send_word(16'h0001, 16, 1'b0, 16'h0, 16'h0001, 4'd0);
        gaps = '0;
        while ($countones(gaps) < 3) begin
            pos = int'($urandom_range(1, 15));
            gaps[pos] = 1'b1;
        end
        send_word(16'h1234, 16, 1'b0, gaps, 16'h1234, 4'd0);
        idle(2);

        // Length-1 word, last flag on a full word, then chained short word
        send_word(16'h8000, 1, 1'b1, 16'h0, 16'h8000, 4'd1);
        send_word(16'h5A5A, 16, 1'b1, 16'h0, 16'h5A5A, 4'd0);
        send_word(16'h6000, 3, 1'b1, 16'h0, 16'h6000, 4'd3);
        idle(2);

        // Reset mid-word discards partial bits
        send_word(16'hFE00, 7, 1'b0, 16'h0, 16'h0, 4'd0);
        ser_data_val_i = 1'b0;
        srst_n_i       = 1'b0;
        tick();
        check("midrst_busy", 32'(busy_o), 32'h0);
        srst_n_i = 1'b1;
        send_word(16'h8001, 16, 1'b0, 16'h0, 16'h8001, 4'd0);
        idle(2);

        // Partial word 1,1,0 then idle
        send_word(16'hC000, 3, 1'b0, 16'h0, 16'h0, 4'd0);
`ifdef DESERIALIZER_TIMEOUT_EN
        push(16'hC000, 4'd3, 1'b1);
        idle(31);
        check("to_early", 32'(deser_data_val_o), 32'h0);
        idle(1);
        check("to_val",  32'(deser_data_val_o), 32'h1);
        check("to_flag", 32'(timeout_o),        32'h1);
        check("to_busy", 32'(busy_o),           32'h0);
        idle(2);
        send_word(16'hC000, 3, 1'b0, 16'h0, 16'h0, 4'd0);
        idle(31);
        send_word(16'hD800, 2, 1'b1, 16'h0, 16'hD800, 4'd5);
`else
        idle(40);
        check("hold_busy", 32'(busy_o), 32'h1);
        send_word(16'hC000, 2, 1'b1, 16'h0, 16'hD800, 4'd5);
`endif
        idle(4);
        check("scoreboard_empty", 32'(q_exp.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
